// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, PC+4, redirect mux, instruction-memory
// request handshake with a one-entry hold buffer, and the IF/ID pipeline register.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemRData,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        REDIR = 2'd2
    } state_t;

    function automatic logic [DATA_W-1:0] pc_inc(input logic [DATA_W-1:0] pc);
        return pc + 32'd4;
    endfunction

    state_t              state, state_n;
    logic [DATA_W-1:0]   pc_p0, pc_n;
    logic [DATA_W-1:0]   tgt_p0, tgt_n;
    logic [DATA_W-1:0]   buf_instr_p0, buf_instr_n;
    logic [DATA_W-1:0]   buf_pc_p0, buf_pc_n;
    logic [DATA_W-1:0]   instr_p1, pc_p1, pcplus4_p1;
    logic                vld_p1;

    logic                adv;
    logic                have_instr;
    logic [DATA_W-1:0]   new_instr;
    logic [DATA_W-1:0]   new_pc;

    // StallF always equals StallD, so only StallD gates the pipeline.
    assign adv = !StallD;

    // While redirecting the PC is left at the outstanding address, so the
    // request address is the PC in every state.
    assign IMemReq  = !rst && (state != HOLD);
    assign IMemAddr = pc_p0;

    always_comb begin
        state_n     = state;
        pc_n        = pc_p0;
        tgt_n       = tgt_p0;
        buf_instr_n = buf_instr_p0;
        buf_pc_n    = buf_pc_p0;
        have_instr  = 1'b0;
        new_instr   = IMemRData;
        new_pc      = pc_p0;
        case (state)
            FETCH: begin
                if (PCSrcE) begin
                    if (IMemReady) begin
                        pc_n = PCTargetE;
                    end else begin
                        tgt_n   = PCTargetE;
                        state_n = REDIR;
                    end
                end else if (IMemReady) begin
                    if (adv) begin
                        have_instr = 1'b1;
                        pc_n       = pc_inc(pc_p0);
                    end else begin
                        buf_instr_n = IMemRData;
                        buf_pc_n    = pc_p0;
                        state_n     = HOLD;
                    end
                end
            end
            HOLD: begin
                if (PCSrcE) begin
                    pc_n    = PCTargetE;
                    state_n = FETCH;
                end else if (adv) begin
                    have_instr = 1'b1;
                    new_instr  = buf_instr_p0;
                    new_pc     = buf_pc_p0;
                    pc_n       = pc_inc(pc_p0);
                    state_n    = FETCH;
                end
            end
            REDIR: begin
                // The wrong-path response is dropped; the newest redirect wins.
                if (IMemReady) begin
                    pc_n    = PCSrcE ? PCTargetE : tgt_p0;
                    state_n = FETCH;
                end else if (PCSrcE) begin
                    tgt_n = PCTargetE;
                end
            end
            default: state_n = FETCH;
        endcase
    end

    // ---- IF stage: PC, redirect target, hold buffer ----
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= FETCH;
            pc_p0        <= RESET_PC;
            tgt_p0       <= RESET_PC;
            buf_instr_p0 <= NOP_INSTR;
            buf_pc_p0    <= RESET_PC;
        end else begin
            state        <= state_n;
            pc_p0        <= pc_n;
            tgt_p0       <= tgt_n;
            buf_instr_p0 <= buf_instr_n;
            buf_pc_p0    <= buf_pc_n;
        end
    end

    // ---- IF/ID register ----
    always_ff @(posedge clk) begin
        if (rst || FlushD || (adv && !have_instr)) begin
            instr_p1   <= NOP_INSTR;
            pc_p1      <= '0;
            pcplus4_p1 <= '0;
            vld_p1     <= 1'b0;
        end else if (adv) begin
            instr_p1   <= new_instr;
            pc_p1      <= new_pc;
            pcplus4_p1 <= pc_inc(new_pc);
            vld_p1     <= 1'b1;
        end
    end

    assign InstrD   = instr_p1;
    assign PCD      = pc_p1;
    assign PCPlus4D = pcplus4_p1;
    assign ValidD   = vld_p1;

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: PC register, PC+4 adder, branch/jump redirect mux, instruction-memory request handshake, and the IF/ID pipeline register.
- Consumes StallF/StallD/FlushD from the hazard unit and PCSrcE/PCTargetE from execute.
- Feeds InstrD/PCD/PCPlus4D to decode.
- Tolerates a multi-cycle instruction memory with a one-entry hold buffer and a redirect-drop state.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset
NOP_INSTR, 32'h00000013, instruction inserted into IF/ID for bubbles (addi x0,x0,0)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
StallF  input  1  hold PC (from hazard unit)
StallD  input  1  hold IF/ID register (from hazard unit)
FlushD  input  1  load bubble into IF/ID (from hazard unit)
PCSrcE  input  1  taken branch/jump resolved in execute
PCTargetE  input  32  redirect target
IMemReq  output  1  fetch request, held until IMemReady
IMemAddr  output  32  fetch address, stable while IMemReq=1
IMemReady  input  1  response valid this cycle; may be high in the same cycle as the request
IMemRData  input  32  instruction, valid when IMemReady=1
InstrD  output  32  IF/ID instruction
PCD  output  32  IF/ID PC
PCPlus4D  output  32  IF/ID PC+4
ValidD  output  1  IF/ID holds a real instruction

Behaviour:
- Reset (rst=1 at edge):
  - PC=RESET_PC, state=FETCH, buffer empty.
  - InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - IMemReq forced 0 while rst=1.
  - A memory response in flight at reset is ignored.
- Stall inputs: StallF and StallD are always driven equal. The IF/ID advance condition is adv = !StallD.
- IF/ID update priority: FlushD, then StallD (hold), then load.
  - FlushD always loads a bubble: NOP_INSTR, ValidD=0, PCD/PCPlus4D=0.
  - A bubble is also loaded whenever adv=1 and no instruction is available.
- PC arithmetic: 32-bit, PC+4 wraps modulo 2^32. No alignment check.
- IMemAddr=PC in FETCH. In REDIR it is the address of the outstanding request.
- FSM states: FETCH, HOLD, REDIR.
- FETCH (IMemReq=1). PCSrcE has priority:
  - PCSrcE & IMemReady: drop the response, PC<=PCTargetE, stay FETCH.
  - PCSrcE & !IMemReady: tgt<=PCTargetE, go REDIR.
  - IMemReady & adv: IF/ID<={IMemRData, PC, PC+4, 1}, PC<=PC+4, stay FETCH.
  - IMemReady & !adv: buf<={IMemRData, PC}, go HOLD. PC unchanged.
  - !IMemReady: stay FETCH. A bubble enters IF/ID if adv.
- HOLD (IMemReq=0):
  - PCSrcE: discard buf, PC<=PCTargetE, go FETCH.
  - adv: IF/ID<={buf.instr, buf.pc, buf.pc+4, 1}, PC<=PC+4, go FETCH.
  - Otherwise hold.
- REDIR (IMemReq=1, old address held):
  - On IMemReady: discard the data, PC<=tgt, go FETCH.
  - A further PCSrcE in REDIR overwrites tgt; the later redirect wins.
  - A bubble enters IF/ID if adv.
  - If PCSrcE and IMemReady coincide, PC<=PCTargetE.
- Latency: with zero-wait memory (IMemReady same cycle), the instruction at PC appears in InstrD one edge later. Throughput is 1 instruction per cycle.
- Redirect penalty: the PCTargetE instruction is fetched in the cycle after PCSrcE. The wrong-path IF/ID entry is flushed by FlushD.
- No instruction is ever delivered twice, and none is skipped, across stall, hold and redirect.

Test Plan:
1. Reset, zero-wait memory returning instr=addr^32'hA5A5_0000 for 4 cycles, no stalls -> PCD=0,4,8,C on consecutive cycles, ValidD=1, InstrD matches, IMemAddr steps by 4.
2. Memory with 2 wait states -> IMemAddr held at 0x0 for 3 cycles, ValidD=0/InstrD=NOP_INSTR inserted while waiting, then PCD=0 delivered once.
3. StallF=StallD=1 for 3 cycles during a response at PC=0x8 -> HOLD entered, IMemReq=0, IF/ID unchanged. On release, PCD=0x8 delivered exactly once, next IMemAddr=0xC.
4. PCSrcE=1, PCTargetE=0x100 with FlushD=1 while request to 0x10 is pending (ready 2 cycles later) -> REDIR, IMemAddr stays 0x10, data at 0x10 discarded, next request 0x100, IF/ID bubble, PCD=0x100 delivered.
5. PCSrcE with IMemReady in the same cycle, and PCSrcE during HOLD -> response/buffer dropped, next IMemAddr=PCTargetE, no wrong-path ValidD=1.
6. rst asserted mid-wait in REDIR, then PC=0xFFFF_FFFC fetch -> after reset IMemAddr=RESET_PC, IMemReq=0 while rst=1. Later PC+4 wraps to 0x0.
